// File: rtl/regscan_pkg.sv
// Shared types and constants for the register-file scan controller.
package regscan_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DUMP_RD   = 3'd1,
        ST_DUMP_WAIT = 3'd2,
        ST_CLEAR     = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_scan_ctrl.sv
// Register-file scan controller: dumps every register over a valid/ready port or clears r1..rN-1.
// Optional macro REGSCAN_ABORT_EN adds an abort input that ends any operation early.
module regfile_scan_ctrl
    import regscan_pkg::*;
#(
    parameter int                 NUM_REGS    = 32,
    parameter logic [DATA_W-1:0]  CLEAR_VALUE = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
`ifdef REGSCAN_ABORT_EN
    input  logic                  abort,
`endif
    output logic [REG_ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0]     bus_a,
    output logic [REG_ADDR_W-1:0] rw,
    output logic [DATA_W-1:0]     bus_w,
    output logic                  reg_wr,
    output logic [DATA_W-1:0]     dump_data,
    output logic [REG_ADDR_W-1:0] dump_idx,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

    state_t                  state_r, state_next_s;
    logic [REG_ADDR_W-1:0]   idx_r, idx_next_s;
    logic                    abort_s;

    logic [REG_ADDR_W-1:0]   ra_r, ra_next_s;
    logic [REG_ADDR_W-1:0]   rw_r, rw_next_s;
    logic [DATA_W-1:0]       bus_w_r, bus_w_next_s;
    logic                    reg_wr_r, reg_wr_next_s;
    logic [DATA_W-1:0]       dump_data_r, dump_data_next_s;
    logic [REG_ADDR_W-1:0]   dump_idx_r, dump_idx_next_s;
    logic                    dump_valid_r, dump_valid_next_s;
    logic                    busy_r, busy_next_s;
    logic                    done_r, done_next_s;

`ifdef REGSCAN_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // State, index and output registers; reset clears everything at once, even mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= 5'd0;
            ra_r         <= 5'd0;
            rw_r         <= 5'd0;
            bus_w_r      <= 32'h0000_0000;
            reg_wr_r     <= 1'b0;
            dump_data_r  <= 32'h0000_0000;
            dump_idx_r   <= 5'd0;
            dump_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            idx_r        <= idx_next_s;
            ra_r         <= ra_next_s;
            rw_r         <= rw_next_s;
            bus_w_r      <= bus_w_next_s;
            reg_wr_r     <= reg_wr_next_s;
            dump_data_r  <= dump_data_next_s;
            dump_idx_r   <= dump_idx_next_s;
            dump_valid_r <= dump_valid_next_s;
            busy_r       <= busy_next_s;
            done_r       <= done_next_s;
        end
    end

    // Next-state and index logic; the index saturates at LAST_IDX and never wraps.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (mode) begin
                        state_next_s = ST_CLEAR;
                        idx_next_s   = 5'd1;
                    end else begin
                        state_next_s = ST_DUMP_RD;
                        idx_next_s   = 5'd0;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DUMP_RD: begin
                if (abort_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DUMP_WAIT;
                end
            end
            ST_DUMP_WAIT: begin
                if (abort_s) begin
                    state_next_s = ST_DONE;
                end else if (dump_ready) begin
                    if (idx_r == LAST_IDX) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_DUMP_RD;
                        idx_next_s   = idx_r + 5'd1;
                    end
                end else begin
                    state_next_s = ST_DUMP_WAIT;
                end
            end
            ST_CLEAR: begin
                if (abort_s || (idx_r == LAST_IDX)) begin
                    state_next_s = ST_DONE;
                end else begin
                    idx_next_s   = idx_r + 5'd1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
                idx_next_s   = 5'd0;
            end
            default: begin
                state_next_s = ST_IDLE;
                idx_next_s   = 5'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output comes straight from a flop.
    always_comb begin
        ra_next_s         = 5'd0;
        rw_next_s         = 5'd0;
        bus_w_next_s      = 32'h0000_0000;
        reg_wr_next_s     = 1'b0;
        dump_valid_next_s = 1'b0;
        busy_next_s       = (state_next_s != ST_IDLE);
        done_next_s       = 1'b0;
        case (state_next_s)
            ST_DUMP_RD: begin
                ra_next_s = idx_next_s;
                rw_next_s = idx_next_s;
            end
            ST_DUMP_WAIT: begin
                ra_next_s         = idx_next_s;
                rw_next_s         = idx_next_s;
                dump_valid_next_s = 1'b1;
            end
            ST_CLEAR: begin
                ra_next_s     = idx_next_s;
                rw_next_s     = idx_next_s;
                bus_w_next_s  = CLEAR_VALUE;
                reg_wr_next_s = 1'b1;
            end
            ST_DONE: begin
                done_next_s = 1'b1;
            end
            ST_IDLE: begin
                busy_next_s = 1'b0;
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
        // BusA is only sampled on the single edge that leaves DUMP_RD for DUMP_WAIT.
        if ((state_r == ST_DUMP_RD) && (state_next_s == ST_DUMP_WAIT)) begin
            dump_data_next_s = bus_a;
            dump_idx_next_s  = idx_r;
        end else begin
            dump_data_next_s = dump_data_r;
            dump_idx_next_s  = dump_idx_r;
        end
    end

    assign ra         = ra_r;
    assign rw         = rw_r;
    assign bus_w      = bus_w_r;
    assign reg_wr     = reg_wr_r;
    assign dump_data  = dump_data_r;
    assign dump_idx   = dump_idx_r;
    assign dump_valid = dump_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// Directed bench for regfile_scan_ctrl with a behavioural register file (negedge commit).
module tb_regfile_scan_ctrl;
    import regscan_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
`ifdef REGSCAN_ABORT_EN
    logic        abort;
`endif
    logic [4:0]  ra;
    logic [31:0] bus_a;
    logic [4:0]  rw;
    logic [31:0] bus_w;
    logic        reg_wr;
    logic [31:0] dump_data;
    logic [4:0]  dump_idx;
    logic        dump_valid;
    logic        dump_ready;
    logic        busy;
    logic        done;

    logic [31:0] rf [0:31];
    bit          preload_req = 1'b0;
    bit          cnt_clr = 1'b0;
    int          wr_cnt;
    int          rw0_cnt;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    regfile_scan_ctrl #(
        .NUM_REGS    (32),
        .CLEAR_VALUE (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
`ifdef REGSCAN_ABORT_EN
        .abort      (abort),
`endif
        .ra         (ra),
        .bus_a      (bus_a),
        .rw         (rw),
        .bus_w      (bus_w),
        .reg_wr     (reg_wr),
        .dump_data  (dump_data),
        .dump_idx   (dump_idx),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .busy       (busy),
        .done       (done)
    );

    assign bus_a = rf[ra];

    // Register file model: preload on request, otherwise commit writes on the falling edge.
    always @(negedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : (32'h100 + i);
        end else if (reg_wr) begin
            rf[rw] <= bus_w;
        end
    end

    // Write-cycle counters, sampled where the file commits.
    always @(negedge clk) begin
        if (cnt_clr) begin
            wr_cnt  <= 0;
            rw0_cnt <= 0;
        end else if (reg_wr) begin
            wr_cnt <= wr_cnt + 1;
            if (rw == 5'd0) rw0_cnt <= rw0_cnt + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic prep;
        preload_req = 1'b1;
        cnt_clr     = 1'b1;
        @(negedge clk);
        #1;
        preload_req = 1'b0;
        cnt_clr     = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] preload_val(input int i);
        return (i == 0) ? 32'h0 : (32'h100 + i);
    endfunction

    // stall=1 gives DumpReady high one cycle in three; poke re-pulses Start at idx 5.
    task automatic run_dump(input string name, input bit stall, input bit poke);
        int          n = 0, beats = 0, order_bad = 0, stall_bad = 0, stalls = 0, wr_seen = 0;
        bit          rd, pv, poked = 1'b0;
        logic [31:0] pd;
        logic [4:0]  pi;
        mode = 1'b0;
        start = 1'b1;
        dump_ready = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            dump_ready = stall ? (k % 3 == 0) : 1'b1;
            rd = dump_ready;
            pv = dump_valid;
            pd = dump_data;
            pi = dump_idx;
            if (poke && !poked && busy && !dump_valid && ra == 5'd5) begin
                start = 1'b1;
                mode  = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
                mode  = 1'b0;
            end
            tick;
            n++;
            if (reg_wr) wr_seen++;
            if (pv && rd) begin
                if (pi !== 5'(beats) || pd !== preload_val(beats)) order_bad++;
                beats++;
            end else if (pv) begin
                stalls++;
                if (dump_valid !== 1'b1 || dump_data !== pd || dump_idx !== pi) stall_bad++;
            end
        end
        start = 1'b0;
        mode  = 1'b0;
        check({name, "_done"}, done, 1);
        check({name, "_beats"}, beats, 32);
        check({name, "_order_bad"}, order_bad, 0);
        check({name, "_no_write"}, wr_seen, 0);
        if (!stall) check({name, "_cycles"}, n, 64);
        if (stall) begin
            check({name, "_stall_bad"}, stall_bad, 0);
            check({name, "_stalls_seen"}, (stalls > 0), 1);
        end
        if (poke) check({name, "_poked"}, poked, 1);
        tick;
        check({name, "_done_pulse"}, done, 0);
        check({name, "_idle"}, busy, 0);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        dump_ready = 1'b0;
`ifdef REGSCAN_ABORT_EN
        abort      = 1'b0;
`endif
        repeat (3) tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", dump_valid, 0);
        check("rst_regwr", reg_wr, 0);
        check("rst_ra", ra, 0);
        check("rst_rw", rw, 0);
        check("rst_busw", bus_w, 0);
        check("rst_ddata", dump_data, 0);
        check("rst_didx", dump_idx, 0);
        rst_n = 1'b1;
        tick;
        check("idle_hold", busy, 0);

        prep;
        run_dump("dump", 1'b0, 1'b0);
        run_dump("stall", 1'b1, 1'b0);
        run_dump("poke", 1'b0, 1'b1);

        // Clear with CLEAR_VALUE = DEADBEEF.
        prep;
        mode = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        mode = 1'b0;
        check("clr_first_rw", rw, 1);
        check("clr_first_wr", reg_wr, 1);
        check("clr_busw", bus_w, 32'hDEAD_BEEF);
        n = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            tick;
            n++;
        end
        check("clr_cycles", n, 31);
        check("clr_wr_cnt", wr_cnt, 31);
        check("clr_rw0", rw0_cnt, 0);
        check("clr_done_regwr", reg_wr, 0);
        check("clr_r0", rf[0], 0);
        for (int i = 1; i < 32; i++) check($sformatf("clr_r%0d", i), rf[i], 32'hDEAD_BEEF);
        tick;
        check("clr_done_pulse", done, 0);

        // Reset while the clear is about to write r10.
        prep;
        mode = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        mode = 1'b0;
        for (int k = 0; k < 50 && !(reg_wr && rw == 5'd10); k++) tick;
        check("rclr_at10", rw, 10);
        rst_n = 1'b0;
        #1;
        check("rclr_regwr", reg_wr, 0);
        check("rclr_busy", busy, 0);
        check("rclr_rw", rw, 0);
        @(negedge clk);
        #1;
        tick;
        rst_n = 1'b1;
        tick;
        for (int i = 1; i < 10; i++) check($sformatf("rclr_r%0d", i), rf[i], 32'hDEAD_BEEF);
        for (int i = 10; i < 32; i++) check($sformatf("rclr_r%0d", i), rf[i], preload_val(i));
        check("rclr_idle", busy, 0);

`ifdef REGSCAN_ABORT_EN
        prep;
        dump_ready = 1'b1;
        mode = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 50 && !(busy && !dump_valid && ra == 5'd3); k++) tick;
        check("abt_at3", ra, 3);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abt_done", done, 1);
        check("abt_valid", dump_valid, 0);
        check("abt_regwr", reg_wr, 0);
        tick;
        check("abt_pulse", done, 0);
        check("abt_idle", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_scan_ctrl.md
REGFILE_SCAN_CTRL -- requirements
Module: regfile_scan_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 32, number of architectural registers scanned (legal range 2..32).
REQ-002 Parameter CLEAR_VALUE, default 32'h0000_0000, value written to each register in clear mode.
REQ-003 Clk  input  1  single clock; all state updates on posedge.
REQ-004 Rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Start  input  1  one-cycle request to begin an operation; sampled only in IDLE.
REQ-006 Mode  input  1  operation select, sampled with Start: 0 = dump, 1 = clear.
REQ-007 RA  output  5  register-file read address.
REQ-008 BusA  input  32  register-file read data, combinational from RA.
REQ-009 RW  output  5  register-file write address.
REQ-010 BusW  output  32  register-file write data.
REQ-011 RegWr  output  1  register-file write enable; the file commits on negedge Clk.
REQ-012 DumpData  output  32  registered contents of the register currently being dumped.
REQ-013 DumpIdx  output  5  index of the register in DumpData.
REQ-014 DumpValid  output  1  DumpData/DumpIdx valid.
REQ-015 DumpReady  input  1  consumer accepts the beat when DumpValid and DumpReady are both high.
REQ-016 Busy  output  1  high in every state except IDLE.
REQ-017 Done  output  1  one-cycle pulse at operation completion.

Function
REQ-018 The FSM SHALL have states IDLE, DUMP_RD, DUMP_WAIT, CLEAR and DONE.
REQ-019 IDLE: Start=1, Mode=0 -> DUMP_RD with idx=0; Start=1, Mode=1 -> CLEAR with idx=1; otherwise stay.
REQ-020 Start asserted outside IDLE SHALL be ignored.
REQ-021 DUMP_RD: RA=idx; on the next edge BusA is captured into DumpData, idx into DumpIdx, DumpValid is set, and the FSM goes to DUMP_WAIT.
REQ-022 DUMP_WAIT: DumpData, DumpIdx and DumpValid SHALL hold stable until DumpReady=1.
REQ-023 DUMP_WAIT on acceptance: DumpValid clears; if idx==NUM_REGS-1 -> DONE, else idx+1 and -> DUMP_RD.
REQ-024 Dump throughput SHALL be at most one beat per 2 cycles; a full 32-register dump with DumpReady tied high SHALL take 64 cycles from Start to DONE entry.
REQ-025 CLEAR: RegWr=1, RW=idx, BusW=CLEAR_VALUE every cycle; idx increments each cycle; idx==NUM_REGS-1 -> DONE.
REQ-026 Register 0 SHALL never be written (RegWr with RW=0 is illegal); clear writes NUM_REGS-1 registers in NUM_REGS-1 cycles.
REQ-027 RegWr SHALL be 0 in every state other than CLEAR.
REQ-028 DONE: Done=1 for exactly one cycle, then -> IDLE.
REQ-029 RA and RW SHALL equal idx while Busy, and 0 in IDLE and DONE; BusW SHALL be 0 outside CLEAR.
REQ-030 idx SHALL be 5 bits wide and SHALL never wrap past NUM_REGS-1.

Reset
REQ-031 Rst_n=0 SHALL immediately force state=IDLE, idx=0, DumpData=0, DumpIdx=0, DumpValid=0, RegWr=0, Done=0 and Busy=0, including mid-operation.
REQ-032 A clear interrupted by reset SHALL leave registers already written cleared and all others untouched; no partial write occurs after reset assertion.

Configuration
REQ-033 With macro REGSCAN_ABORT_EN defined, an input Abort (1 bit) SHALL exist; Abort=1 in DUMP_RD, DUMP_WAIT or CLEAR forces DONE on the next edge, with DumpValid=0 and RegWr=0 from that edge.
REQ-034 Without REGSCAN_ABORT_EN, the Abort port SHALL be absent and operations SHALL always run to completion.

Structure
REQ-035 Package regscan_pkg SHALL hold the state enumeration and the constants REG_ADDR_W=5 and DATA_W=32.
REQ-036 The block SHALL be a single module (FSM plus index counter), with no sub-module.

Verification
REQ-037 Preload r1..r31 = 32'h100+i, DumpReady=1, Start Mode=0 -> 32 beats, DumpIdx 0..31, DumpData 0, 0x101..0x11F, one Done, 64 cycles.
REQ-038 Dump with DumpReady toggled 1-of-3 cycles -> no beat lost or duplicated, and DumpData stable while stalled.
REQ-039 CLEAR_VALUE=32'hDEAD_BEEF, Start Mode=1 -> r1..r31 read 0xDEADBEEF, r0 reads 0, 31 RegWr cycles, RW never 0.
REQ-040 Start pulsed again mid-dump at idx=5 -> ignored; the sequence continues unchanged.
REQ-041 Rst_n low during clear at idx=10 -> RegWr drops asynchronously, r1..r9 cleared, r10..r31 hold preload, Busy=0.
REQ-042 REGSCAN_ABORT_EN: Abort at dump idx=3 -> next cycle DONE, Done pulse, DumpValid=0, then IDLE.
